pipeline_state_dumper: RTL and testbench

//  Debug reader for the 5-stage MIPS pipeline's observation bus. On a start pulse it

---
 rtl/pipeline_state_dumper.sv | 148 ++++++++++++++
 tb/tb_pipeline_state_dumper.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_state_dumper.sv
// pipeline_state_dumper
//   Debug reader for the pipeline observation bus. A start pulse in IDLE
//   snapshots the PC, register file and data memory, then streams the
//   snapshot as a framed byte sequence over a valid/ready byte interface:
//     0xA5 | PC (16 b, MSB first) | reg0..regN-1 | mem0..memM-1 | checksum
//   Words are sent MSB first. The checksum is the XOR of every byte between
//   the header and the checksum byte.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     dump request, only honoured in IDLE
//   pc_in     current PC
//   regs_in   register i at [i*DATA_W +: DATA_W]
//   mem_in    memory word j at [j*DATA_W +: DATA_W]
//   tx_data   byte presented downstream
//   tx_valid  tx_data is valid; held with tx_data until accepted
//   tx_ready  downstream accepts when tx_valid && tx_ready
//   busy      high in every state except IDLE
//   done      one-cycle pulse after the checksum byte is accepted
//
// State | meaning
//   IDLE  | waiting for start; snapshot loaded on the start edge
//   HDR   | presenting the 0xA5 header byte
//   PC    | streaming the 2 PC bytes
//   REGS  | streaming register-file bytes
//   MEM   | streaming data-memory bytes
//   CSUM  | presenting the accumulated checksum
//   DONE  | done pulse, returns to IDLE
module pipeline_state_dumper #(
  parameter int PC_W     = 10,
  parameter int NUM_REGS = 32,
  parameter int NUM_MEM  = 10,
  parameter int DATA_W   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [PC_W-1:0]            pc_in,
  input  logic [NUM_REGS*DATA_W-1:0] regs_in,
  input  logic [NUM_MEM*DATA_W-1:0]  mem_in,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int REG_BYTES = NUM_REGS * DATA_W / 8;
  localparam int MEM_BYTES = NUM_MEM * DATA_W / 8;
  localparam int MAX_BYTES = (REG_BYTES > MEM_BYTES) ? REG_BYTES : MEM_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES);
  localparam int PAY_BITS  = 16 + (NUM_REGS + NUM_MEM) * DATA_W;

  typedef enum logic [2:0] {IDLE, HDR, PC, REGS, MEM, CSUM, DONE} stateT;

  stateT               state, stateNext;
  logic [PAY_BITS-1:0] snapReg;
  logic [PAY_BITS-1:0] loadVec;
  logic [7:0]          csum;
  logic [CNT_W-1:0]    byteCnt;
  logic                xfer;
  logic                payloadState;
  logic                lastByte;

  // The snapshot is held pre-ordered in transmit order so the next payload
  // byte is always the top byte; each accepted byte shifts it out.
  always_comb begin
    loadVec = '0;
    loadVec[PAY_BITS-1 -: 16] = 16'(pc_in);
    for (int i = 0; i < NUM_REGS; i++)
      loadVec[PAY_BITS-17-i*DATA_W -: DATA_W] = regs_in[i*DATA_W +: DATA_W];
    for (int j = 0; j < NUM_MEM; j++)
      loadVec[PAY_BITS-17-(NUM_REGS+j)*DATA_W -: DATA_W] = mem_in[j*DATA_W +: DATA_W];
  end

  always_comb begin
    xfer         = tx_valid && tx_ready;
    payloadState = (state == PC) || (state == REGS) || (state == MEM);
    case (state)
      PC:      lastByte = (byteCnt == CNT_W'(1));
      REGS:    lastByte = (byteCnt == CNT_W'(REG_BYTES - 1));
      MEM:     lastByte = (byteCnt == CNT_W'(MEM_BYTES - 1));
      default: lastByte = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      snapReg <= '0;
      csum    <= '0;
      byteCnt <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && start) begin
        snapReg <= loadVec;
        csum    <= '0;
        byteCnt <= '0;
      end else if (payloadState && xfer) begin
        snapReg <= snapReg << 8;
        csum    <= csum ^ snapReg[PAY_BITS-1 -: 8];
        byteCnt <= lastByte ? '0 : byteCnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    stateNext = state;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) stateNext = HDR;
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        if (xfer) stateNext = PC;
      end
      PC, REGS, MEM: begin
        tx_valid = 1'b1;
        tx_data  = snapReg[PAY_BITS-1 -: 8];
        if (xfer && lastByte) begin
          case (state)
            PC:      stateNext = REGS;
            REGS:    stateNext = MEM;
            default: stateNext = CSUM;
          endcase
        end
      end
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        if (xfer) stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pipeline_state_dumper.sv
module tb_pipeline_state_dumper;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [9:0]    pc_in;
  logic [1023:0] regs_in;
  logic [319:0]  mem_in;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          done;

  pipeline_state_dumper dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in),
    .regs_in(regs_in), .mem_in(mem_in), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         fails = 0;
  logic [7:0] expQ[$];
  int         doneCount = 0;
  int         xferCount = 0;
  logic [7:0] lastRx = 8'h00;
  logic       prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference frame built from the currently driven inputs.
  function automatic void pushFrame();
    logic [7:0]  pay[$];
    logic [7:0]  cs = 8'h00;
    logic [15:0] p16 = {6'b0, pc_in};
    logic [31:0] w;
    pay.push_back(p16[15:8]);
    pay.push_back(p16[7:0]);
    for (int i = 0; i < 32; i++) begin
      w = regs_in[i*32 +: 32];
      for (int k = 3; k >= 0; k--) pay.push_back(w[k*8 +: 8]);
    end
    for (int j = 0; j < 10; j++) begin
      w = mem_in[j*32 +: 32];
      for (int k = 3; k >= 0; k--) pay.push_back(w[k*8 +: 8]);
    end
    expQ.push_back(8'hA5);
    foreach (pay[n]) begin
      cs = cs ^ pay[n];
      expQ.push_back(pay[n]);
    end
    expQ.push_back(cs);
  endfunction

  // Monitor: pops the scoreboard on every accepted byte.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset) begin
      if (prevStall) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, prevData);
      end
      if (tx_valid) check("busy_with_valid", busy, 1);
      if (tx_valid && tx_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_byte actual=%0h required=none", tx_data);
        end else begin
          e = expQ.pop_front();
          check("byte", tx_data, e);
        end
        xferCount++;
        lastRx = tx_data;
      end
      if (done) begin
        check("done_queue_empty", expQ.size(), 0);
        check("done_no_valid", tx_valid, 0);
        doneCount++;
      end
      prevStall = tx_valid && !tx_ready;
      prevData  = tx_data;
    end else begin
      prevStall = 1'b0;
    end
  end

  task automatic randInputs();
    pc_in = 10'($urandom);
    for (int i = 0; i < 32; i++) regs_in[i*32 +: 32] = $urandom;
    for (int j = 0; j < 10; j++) mem_in[j*32 +: 32] = $urandom;
  endtask

  task automatic t1Inputs();
    pc_in = 10'h3FF;
    for (int i = 0; i < 32; i++) regs_in[i*32 +: 32] = 32'(i);
    for (int j = 0; j < 10; j++) mem_in[j*32 +: 32] = 32'(32'h100 + j);
  endtask

  task automatic setReady(input int mode, inout int stall);
    case (mode)
      0: tx_ready = 1'b1;
      1: tx_ready = 1'($urandom_range(0, 1));
      default: begin
        if (xferCount == 10 && stall > 0) begin
          tx_ready = 1'b0;
          stall--;
        end else tx_ready = 1'b1;
      end
    endcase
  endtask

  // mode: 0 ready high, 1 random ready, 2 five-cycle stall on byte 10
  task automatic runFrame(input int mode, input bit mutate, input bit spam, input int abortAt);
    int d0 = doneCount;
    int stall = 5;
    @(posedge clk); #1;
    xferCount = 0;
    start = 1'b1;
    pushFrame();
    @(posedge clk); #1;
    if (!spam) start = 1'b0;
    if (mutate) begin
      regs_in = '1;
      pc_in   = 10'($urandom);
      for (int j = 0; j < 10; j++) mem_in[j*32 +: 32] = $urandom;
    end
    setReady(mode, stall);
    @(negedge clk);
    check("first_valid", tx_valid, 1);
    check("first_byte", tx_data, 8'hA5);
    for (int c = 0; c < 4000 && doneCount == d0; c++) begin
      @(posedge clk); #1;
      if (abortAt >= 0 && xferCount >= abortAt) begin
        reset = 1'b1;
        start = 1'b0;
        expQ.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_valid", tx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_data", tx_data, 0);
        return;
      end
      setReady(mode, stall);
    end
    start = 1'b0;
    if (doneCount == d0) begin
      checks++;
      fails++;
      $display("FAIL frame_timeout actual=no_done required=done");
    end
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_valid", tx_valid, 0);
    repeat (5) @(negedge clk);
    check("one_done", doneCount - d0, 1);
    check("frame_len", xferCount, 172);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    tx_ready = 1'b0;
    pc_in    = '0;
    regs_in  = '0;
    mem_in   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", tx_data, 0);

    t1Inputs();
    runFrame(0, 0, 0, -1);
    check("t1_csum", lastRx, 8'hFD);

    t1Inputs();
    runFrame(0, 1, 0, -1);
    check("t2_csum", lastRx, 8'hFD);

    t1Inputs();
    runFrame(2, 0, 0, -1);
    check("t3_csum", lastRx, 8'hFD);

    randInputs();
    runFrame(1, 0, 1, -1);

    randInputs();
    runFrame(0, 0, 0, 50);
    randInputs();
    runFrame(0, 0, 0, -1);

    pc_in   = '0;
    regs_in = '0;
    mem_in  = '0;
    runFrame(0, 0, 0, -1);
    check("t6_csum", lastRx, 8'h00);

    for (int r = 0; r < 6; r++) begin
      randInputs();
      runFrame(1, r[0], 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
